obstacle_spawn_scheduler: RTL and testbench

Sequences obstacle generation for the dino game: decides when the next obstacle spawns, which of the two obstacle slots receives it, which sprite type it uses, and the scroll speed level. Sits between the game-state/score logic and the obstacle slot engine. Consumes the 60 Hz game tick, the game start/frozen flags, the BCD score and the LFSR output. Issues spawn requests over a req/ack handshake.

---
 rtl/dino_pkg.sv | 29 ++
 rtl/obstacle_spawn_scheduler_if.sv | 10 +
 rtl/spawn_gap_timer.sv | 22 ++
 rtl/obstacle_spawn_scheduler.sv | 123 ++++++++++++
 tb/tb_obstacle_spawn_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino game obstacle pipeline: scheduler states,
// obstacle sprite codes, gap width and the type-folding helper.
package dino_pkg;

    localparam int GAP_W         = 8;
    localparam int NUM_TYPES_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ARB,
        S_REQ,
        S_FROZEN
    } state_t;

    typedef enum logic [2:0] {
        OBS_CACTUS_SM,
        OBS_CACTUS_LG,
        OBS_CACTUS_GRP,
        OBS_BIRD_LO,
        OBS_BIRD_HI
    } obs_type_t;

    // Fold a 3-bit random value into 0..n-1 with a single subtraction.
    function automatic logic [2:0] map_type(input logic [2:0] r, input int n);
        return (int'(r) < n) ? r : r - 3'(n);
    endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_if.sv
// Spawn request handshake between the scheduler (master) and the slot engine (slave).
interface obstacle_spawn_scheduler_if;
    logic       spawn_req;
    logic       spawn_slot;
    logic [2:0] spawn_type;
    logic       spawn_ack;

    modport master (output spawn_req, spawn_slot, spawn_type, input spawn_ack);
    modport slave  (input spawn_req, spawn_slot, spawn_type, output spawn_ack);
endinterface

// File: rtl/spawn_gap_timer.sv
// Loadable 8-bit down-counter measuring game ticks between spawns; saturates at zero.
module spawn_gap_timer
    import dino_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             tick_en,
    output logic [GAP_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cnt <= '0;
        else if (load)                  cnt <= load_val;
        else if (tick_en && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle spawn scheduler: gap timing, round-robin slot choice, sprite type and speed level.
// Optional build macro SPAWN_DOUBLE_EN shortens the gap after a spawn to create obstacle pairs.
module obstacle_spawn_scheduler
    import dino_pkg::*;
#(
    parameter int MIN_GAP   = 40,
    parameter int SPEED_MAX = 4,
    parameter int NUM_TYPES = NUM_TYPES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_tick,
    input  logic        game_start,
    input  logic        game_frozen,
    input  logic [15:0] score,
    input  logic [7:0]  rng,
    input  logic [1:0]  slot_busy,
    obstacle_spawn_scheduler_if.master sp,
    output logic [2:0]  speed
);

    state_t           state, nxt;
    logic [GAP_W-1:0] gap_cnt, gap_val, reload_val;
    logic             gap_zero, gap_load, tick_en;
    logic             last_grant, grant, clr_last, ack_take;
    logic [1:0]       free;
    logic [3:0]       spd_sum;
    logic [2:0]       speed_calc;
    logic             unused_score;

    assign unused_score = ^score[8:0];
    assign free         = ~slot_busy;
    // Both free: the slot not granted last time; otherwise the only free one.
    assign grant        = (&free) ? ~last_grant : free[1];
    assign tick_en      = (state == S_WAIT) && game_tick;

`ifdef SPAWN_DOUBLE_EN
    assign reload_val = (rng[7] && !slot_busy[~sp.spawn_slot])
                      ? GAP_W'(MIN_GAP / 4)
                      : GAP_W'(MIN_GAP) + GAP_W'(rng[7:3]);
`else
    assign reload_val = GAP_W'(MIN_GAP) + GAP_W'(rng[7:3]);
`endif

    spawn_gap_timer u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_val),
        .tick_en  (tick_en),
        .cnt      (gap_cnt),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        gap_load = 1'b0;
        gap_val  = GAP_W'(MIN_GAP);
        clr_last = 1'b0;
        ack_take = 1'b0;
        if (game_start) begin
            nxt      = S_WAIT;
            gap_load = 1'b1;
            clr_last = 1'b1;
        end else begin
            case (state)
                S_IDLE:   nxt = S_IDLE;
                // Leave on the same edge as the tick that reaches zero.
                S_WAIT: begin
                    if (game_frozen) nxt = S_FROZEN;
                    else if (gap_zero || (game_tick && gap_cnt == GAP_W'(1))) nxt = S_ARB;
                end
                S_ARB: begin
                    if (game_frozen) nxt = S_FROZEN;
                    else if (|free)  nxt = S_REQ;
                end
                S_REQ: begin
                    if (game_frozen) nxt = S_FROZEN;
                    else if (sp.spawn_ack) begin
                        nxt      = S_WAIT;
                        gap_load = 1'b1;
                        gap_val  = reload_val;
                        ack_take = 1'b1;
                    end
                end
                S_FROZEN: nxt = S_FROZEN;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    assign spd_sum = 4'd1 + {1'b0, score[11:9]};

    always_comb begin
        speed_calc = spd_sum[2:0];
        if (score[15:12] != 4'd0 || spd_sum > 4'(SPEED_MAX)) speed_calc = 3'(SPEED_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp.spawn_req  <= 1'b0;
            sp.spawn_slot <= 1'b0;
            sp.spawn_type <= 3'd0;
            last_grant    <= 1'b1;
            speed         <= 3'd1;
        end else begin
            sp.spawn_req <= (nxt == S_REQ);
            if (state == S_ARB && nxt == S_REQ) begin
                sp.spawn_slot <= grant;
                sp.spawn_type <= map_type(rng[2:0], NUM_TYPES);
            end
            if (clr_last)      last_grant <= 1'b1;
            else if (ack_take) last_grant <= sp.spawn_slot;
            if (state != S_FROZEN) speed <= speed_calc;
        end
    end

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Bench for obstacle_spawn_scheduler: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the spawn rules.
module tb_obstacle_spawn_scheduler;
    import dino_pkg::*;

    localparam int MIN_GAP   = 40;
    localparam int SPEED_MAX = 4;
    localparam int NUM_TYPES = 5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        game_tick = 1'b0, game_start = 1'b0, game_frozen = 1'b0;
    logic [15:0] score = 16'h0000;
    logic [7:0]  rng = 8'h00;
    logic [1:0]  slot_busy = 2'b00;
    logic [2:0]  speed;

    obstacle_spawn_scheduler_if sp_if ();

    obstacle_spawn_scheduler #(
        .MIN_GAP(MIN_GAP), .SPEED_MAX(SPEED_MAX), .NUM_TYPES(NUM_TYPES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_start(game_start),
        .game_frozen(game_frozen), .score(score), .rng(rng), .slot_busy(slot_busy),
        .sp(sp_if), .speed(speed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_print = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the game is off, counting ticks, picking a slot,
    // offering a spawn, or halted.
    localparam int M_OFF = 0, M_COUNT = 1, M_PICK = 2, M_OFFER = 3, M_HALT = 4;
    int m_mode, m_left, m_last, m_slot, m_type, m_speed, m_prev;
    bit m_req;

    function automatic int reload(input logic [7:0] r, input logic [1:0] busy, input int slot);
`ifdef SPAWN_DOUBLE_EN
        if (r[7] && !busy[1-slot]) return MIN_GAP / 4;
`endif
        return MIN_GAP + int'(r[7:3]);
    endfunction

    function automatic int speed_of(input logic [15:0] s);
        int thousands = int'(s) / 4096;
        int hundreds  = (int'(s) / 256) % 16;
        if (thousands != 0) return SPEED_MAX;
        return (1 + hundreds / 2 < SPEED_MAX) ? 1 + hundreds / 2 : SPEED_MAX;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_OFF; m_left = 0; m_last = 1; m_req = 0;
            m_slot = 0; m_type = 0; m_speed = 1;
        end else begin
            m_prev = m_mode;
            if (game_start) begin
                m_mode = M_COUNT; m_left = MIN_GAP; m_last = 1;
            end else if (m_mode != M_OFF && m_mode != M_HALT && game_frozen) begin
                m_mode = M_HALT;
            end else if (m_mode == M_COUNT) begin
                if (game_tick && m_left > 0) m_left--;
                if (m_left == 0) m_mode = M_PICK;
            end else if (m_mode == M_PICK && slot_busy != 2'b11) begin
                if (slot_busy == 2'b00) m_slot = 1 - m_last;
                else                    m_slot = slot_busy[0] ? 1 : 0;
                m_type = int'(rng) % 8;
                if (m_type >= NUM_TYPES) m_type -= NUM_TYPES;
                m_mode = M_OFFER;
            end else if (m_mode == M_OFFER && sp_if.spawn_ack) begin
                m_last = m_slot;
                m_left = reload(rng, slot_busy, m_slot);
                m_mode = M_COUNT;
            end
            m_req = (m_mode == M_OFFER);
            if (m_prev != M_HALT) m_speed = speed_of(score);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (sp_if.spawn_req !== m_req || int'(speed) != m_speed ||
                (m_req && (int'(sp_if.spawn_slot) != m_slot || int'(sp_if.spawn_type) != m_type))) begin
                n_bad++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL model t=%0t: req/slot/type/speed got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                             $time, sp_if.spawn_req, sp_if.spawn_slot, sp_if.spawn_type, speed,
                             m_req, m_slot, m_type, m_speed);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            game_tick = 1'b1;
            @(negedge clk);
        end
        game_tick = 1'b0;
    endtask

    task automatic pulse_ack(input logic [7:0] r);
        rng = r;
        sp_if.spawn_ack = 1'b1;
        @(negedge clk);
        sp_if.spawn_ack = 1'b0;
    endtask

    task automatic start_game();
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
    endtask

    logic [15:0] sc_tab [5] = '{16'h0000, 16'h0300, 16'h0900, 16'h1000, 16'h0500};
    int          sp_tab [5] = '{1, 2, 4, 4, 3};
    int          bad_hold;

    initial begin
        sp_if.spawn_ack = 1'b0;
        cyc(3);
        chk("rst_req",   int'(sp_if.spawn_req), 0);
        chk("rst_slot",  int'(sp_if.spawn_slot), 0);
        chk("rst_type",  int'(sp_if.spawn_type), 0);
        chk("rst_speed", int'(speed), 1);
        chk("rst_state", int'(dut.state), int'(S_IDLE));
        chk("rst_gap",   int'(dut.gap_cnt), 0);
        rst_n = 1'b1;
        cyc(2);

        // First spawn: 40 ticks, request two cycles after the last one.
        start_game();
        ticks(40);
        chk("req_in_arb", int'(sp_if.spawn_req), 0);
        cyc(1);
        chk("req_first", int'(sp_if.spawn_req), 1);
        chk("slot_first", int'(sp_if.spawn_slot), 0);

        // rng=F8 gives a 71-tick gap and the next spawn alternates to slot 1.
        pulse_ack(8'hF8);
        rng = 8'h00;
        ticks(70);
        cyc(1);
        chk("gap71_not_yet", int'(sp_if.spawn_req), 0);
        ticks(1);
        cyc(1);
        chk("gap71_req", int'(sp_if.spawn_req), 1);
        chk("slot_second", int'(sp_if.spawn_slot), 1);

        pulse_ack(8'h00);
        ticks(40);
        cyc(1);
        chk("req_third", int'(sp_if.spawn_req), 1);
        chk("slot_third", int'(sp_if.spawn_slot), 0);

        // Both slots busy: stall in ARB until slot 1 frees up.
        pulse_ack(8'h00);
        slot_busy = 2'b11;
        ticks(40);
        cyc(3);
        chk("busy_noreq", int'(sp_if.spawn_req), 0);
        chk("busy_arb", int'(dut.state), int'(S_ARB));
        slot_busy = 2'b01;
        cyc(1);
        chk("free1_req", int'(sp_if.spawn_req), 1);
        chk("free1_slot", int'(sp_if.spawn_slot), 1);

        // rng[2:0]=6 folds to type 1; request held stable without ack.
        slot_busy = 2'b00;
        pulse_ack(8'h00);
        rng = 8'h06;
        ticks(40);
        cyc(1);
        chk("type6_req", int'(sp_if.spawn_req), 1);
        chk("type6_type", int'(sp_if.spawn_type), 1);
        chk("type6_slot", int'(sp_if.spawn_slot), 0);
        bad_hold = 0;
        for (int i = 0; i < 100; i++) begin
            rng = 8'($urandom);
            slot_busy = 2'($urandom);
            @(negedge clk);
            if (sp_if.spawn_req !== 1'b1 || sp_if.spawn_slot !== 1'b0 || sp_if.spawn_type !== 3'd1)
                bad_hold++;
        end
        chk("hold100_unstable", bad_hold, 0);

        // Freeze during REQ, then simultaneous start and freeze.
        game_frozen = 1'b1;
        cyc(1);
        game_frozen = 1'b0;
        chk("frozen_req", int'(sp_if.spawn_req), 0);
        chk("frozen_state", int'(dut.state), int'(S_FROZEN));
        cyc(2);
        game_start = 1'b1;
        game_frozen = 1'b1;
        cyc(1);
        game_start = 1'b0;
        game_frozen = 1'b0;
        chk("restart_state", int'(dut.state), int'(S_WAIT));
        chk("restart_gap", int'(dut.gap_cnt), 40);

        // Speed level with one cycle of latency.
        for (int i = 0; i < 5; i++) begin
            score = sc_tab[i];
            cyc(1);
            chk($sformatf("speed_%04h", sc_tab[i]), int'(speed), sp_tab[i]);
        end

        // Random traffic, checked by the model each cycle.
        for (int i = 0; i < 4000; i++) begin
            game_tick       = ($urandom % 3) != 0;
            sp_if.spawn_ack = ($urandom % 4) == 0;
            rng             = 8'($urandom);
            slot_busy       = 2'($urandom);
            game_frozen     = ($urandom % 97) == 0;
            game_start      = ($urandom % 151) == 0;
            if ($urandom % 50 == 0) score = 16'($urandom);
            @(negedge clk);
        end
        game_tick = 1'b0; sp_if.spawn_ack = 1'b0; game_frozen = 1'b0;
        game_start = 1'b0; slot_busy = 2'b00;
        cyc(1);

        // Reset in the middle of a handshake clears the request at once.
        start_game();
        ticks(40);
        cyc(1);
        chk("pre_rst_req", int'(sp_if.spawn_req), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_req", int'(sp_if.spawn_req), 0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
